minority4: RTL and testbench



---
 rtl/minority_pkg.sv | 15 +
 rtl/minority4_popcount4.sv | 14 +
 rtl/minority4.sv | 43 ++++
 tb/tb_minority4.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/minority_pkg.sv
// Shared constants and helpers for the 4-input minority voter.
package minority_pkg;

    // Number of vote inputs handled by the voter.
    localparam int MINORITY4_N = 4;

    // Largest count of ones that still counts as a minority of ones.
    localparam logic [2:0] MINORITY4_MAX_ONES = 3'd1;

    // Count the ones in a 4-bit vector; the result range is 0..4.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/minority4_popcount4.sv
// Combinational ones counter for the four vote inputs.
module popcount4
    import minority_pkg::*;
(
    input  logic [MINORITY4_N-1:0] v,
    output logic [2:0]             cnt
);

    // Three bits hold the full 0..4 range, so the sum cannot overflow.
    always_comb begin
        cnt = popcount4(v);
    end

endmodule

// File: rtl/minority4.sv
// Registered 4-input minority voter: Z=1 when ones are strictly fewer than
// zeros among A,B,C,D. A 2-2 tie gives Z=0. One cycle of latency.
module minority4
    import minority_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic Z
);

    logic [MINORITY4_N-1:0] w_votes;
    logic [2:0]             w_ones;
    logic                   w_z_next;
    logic                   r_z;

    assign w_votes = {A, B, C, D};

    popcount4 u_popcount4 (
        .v   (w_votes),
        .cnt (w_ones)
    );

    // Minority of ones means at most MINORITY4_MAX_ONES inputs are high.
    always_comb begin
        w_z_next = (w_ones <= MINORITY4_MAX_ONES);
    end

    // Output flop; reset forces 0 even though all-zero inputs would vote 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_z_next;
        end
    end

    assign Z = r_z;

endmodule

// File: tb/tb_minority4.sv
// Directed, table-driven bench for the registered 4-input minority voter.
module tb_minority4;

    logic clk;
    logic rst_n;
    logic A, B, C, D;
    logic Z;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] abcd;
        logic       z;
    } vec_t;

    vec_t vecs [25];

    minority4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .Z     (Z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: Z=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {A, B, C, D} = v;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Exhaustive sweep, expected Z hand-derived from the count of ones.
        vecs[0]  = '{4'b0000, 1'b1};
        vecs[1]  = '{4'b0001, 1'b1};
        vecs[2]  = '{4'b0010, 1'b1};
        vecs[3]  = '{4'b0011, 1'b0};
        vecs[4]  = '{4'b0100, 1'b1};
        vecs[5]  = '{4'b0101, 1'b0};
        vecs[6]  = '{4'b0110, 1'b0};
        vecs[7]  = '{4'b0111, 1'b0};
        vecs[8]  = '{4'b1000, 1'b1};
        vecs[9]  = '{4'b1001, 1'b0};
        vecs[10] = '{4'b1010, 1'b0};
        vecs[11] = '{4'b1011, 1'b0};
        vecs[12] = '{4'b1100, 1'b0};
        vecs[13] = '{4'b1101, 1'b0};
        vecs[14] = '{4'b1110, 1'b0};
        vecs[15] = '{4'b1111, 1'b0};
        // Ties: two ones, two zeros.
        vecs[16] = '{4'b0011, 1'b0};
        vecs[17] = '{4'b0101, 1'b0};
        vecs[18] = '{4'b0110, 1'b0};
        vecs[19] = '{4'b1001, 1'b0};
        vecs[20] = '{4'b1010, 1'b0};
        vecs[21] = '{4'b1100, 1'b0};
        // Extremes.
        vecs[22] = '{4'b0111, 1'b0};
        vecs[23] = '{4'b1111, 1'b0};
        vecs[24] = '{4'b0000, 1'b1};

        // Reset asserted with all-zero inputs: Z must be 0 before any edge.
        rst_n = 1'b0;
        drive(4'b0000);
        #2;
        check("reset_no_clock", Z, 1'b0);

        // Held in reset across an edge, Z stays 0.
        @(posedge clk);
        #1;
        check("reset_held_edge", Z, 1'b0);

        // Release between edges; the first edge loads the vote for 0000.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", Z, 1'b0);
        @(posedge clk);
        #1;
        check("release_first_edge", Z, 1'b1);

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vecs[i].abcd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_%b", i, vecs[i].abcd), Z, vecs[i].z);
        end

        // Latency: input change between edges is not visible until next edge.
        @(negedge clk);
        drive(4'b0000);
        @(posedge clk);
        #1;
        check("lat_setup_0000", Z, 1'b1);
        drive(4'b1111);
        #2;
        check("lat_hold_before_edge", Z, 1'b1);
        @(negedge clk);
        check("lat_hold_negedge", Z, 1'b1);
        @(posedge clk);
        #1;
        check("lat_after_edge", Z, 1'b0);

        // Mid-run reset pulse shorter than a cycle, with 0001 held.
        @(negedge clk);
        drive(4'b0001);
        @(posedge clk);
        #1;
        check("midrst_setup", Z, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_drop", Z, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_released_no_edge", Z, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_recover", Z, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
